fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of memoryAccess.
- Owns the PC register and drives pcF into memoryAccess's pc input; receives the combinationally read instruction word back on instrF.
- Registers the fetched word into the IF/ID pipeline register for decode.
- Gated by the board start switch, stops on a HALT encoding, and applies stall/flush/redirect from the hazard unit and execute stage.

Parameters:
- WIDTH, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC value after reset and while idle.
- PC_STEP, 4, sequential PC increment.
- NOP_INSTR, 32'h0000_0000, encoding inserted as a bubble.
- HALT_INSTR, 32'hFFFF_FFFF, encoding that stops fetch.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- switchStart  in  1  level; enables fetch from IDLE.
- instrF  in  WIDTH  instruction read by memoryAccess at address pcF (same cycle).
- stallF  in  1  hold PC.
- stallD  in  1  hold IF/ID register.
- flushD  in  1  replace IF/ID contents with a bubble.
- pcSrcE  in  1  taken branch/jump in execute.
- pcTargetE  in  WIDTH  redirect target.
- pcF  out  WIDTH  current fetch address (to memoryAccess pc).
- instrD  out  WIDTH  IF/ID instruction.
- pcD  out  WIDTH  IF/ID PC.
- pcPlus4D  out  WIDTH  IF/ID PC+PC_STEP.
- validD  out  1  IF/ID holds a real instruction.
- running  out  1  state==RUN.
- halted  out  1  state==HALT.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: pcF=RESET_PC, instrD=NOP_INSTR, pcD=0, pcPlus4D=0, validD=0, state=IDLE, running=0, halted=0. Reset mid-operation discards everything the same cycle it is sampled.
- FSM states: IDLE, RUN, HALT.
- IDLE:
  - pcF is held at RESET_PC; IF/ID loads a bubble each cycle.
  - switchStart=1 sampled -> RUN next cycle. The first fetch of RESET_PC is latched into D on the following edge.
- RUN, next pcF priority (highest first):
  - pcSrcE: pcF <= {pcTargetE[WIDTH-1:2],2'b00}.
  - stallF: hold pcF.
  - instrF==HALT_INSTR: hold pcF, state -> HALT.
  - Otherwise: pcF <= pcF+PC_STEP. Modulo 2^WIDTH; 32'hFFFF_FFFC wraps to 0.
- IF/ID update priority (highest first):
  - flushD or pcSrcE: bubble (instrD=NOP_INSTR, validD=0, pcD/pcPlus4D don't-care but driven to 0).
  - stallD: hold all D outputs.
  - RUN: load instrF, pcF, pcF+PC_STEP; validD=1.
  - Not RUN: bubble.
- HALT_INSTR itself is latched into D (validD=1) on the cycle it is detected, so decode sees it. It is not detected while stallF=1 or pcSrcE=1; it is re-evaluated next cycle.
- HALT:
  - pcF frozen; D loads bubbles.
  - pcSrcE=1 (an older branch was taken, so the halt was speculative) -> RUN with pcF=target. The halt in D is flushed by the same rule above.
  - switchStart is ignored; only rst or redirect leaves HALT.
- switchStart deasserting while in RUN has no effect.
- Latency: instruction at pcF appears on instrD one cycle later. Redirect costs one bubble in D.
- pcSrcE and stallF asserted together: redirect wins.
- flushD and stallD asserted together: flush wins.

Decomposition:
- Shared package processor_pkg: fetch_state_t enum {IDLE,RUN,HALT}; constants NOP_INSTR, HALT_INSTR, PC_STEP, RESET_PC (parameters default to these).
- One natural sub-module: if_id_register. It holds the IF/ID flops with stall/flush/load controls.
- The PC register and FSM stay in fetch_stage.

Test Plan:
- Reset, switchStart=0 for 5 cycles -> pcF=0, validD=0, instrD=0, running=0. Then switchStart=1 -> running=1 next cycle; pcF steps 0,4,8,12; instrD follows one cycle behind with validD=1.
- stallF=stallD=1 for 2 cycles at pcF=8 -> pcF stays 8, D holds the instruction from pcF=4. On release, pcF=12 next.
- pcSrcE=1, pcTargetE=32'h0000_0103 with stallF=1 -> pcF=32'h100 next cycle, validD=0 for that cycle, fetch resumes at 0x104.
- instrF=32'hFFFF_FFFF at pcF=0x20 -> next cycle halted=1, pcF=0x20, instrD=32'hFFFF_FFFF, validD=1; the cycle after, validD=0; pcF stays 0x20 with switchStart toggling.
- In HALT, pcSrcE=1, pcTargetE=0x40 -> running=1, pcF=0x40, D bubble; then normal fetch from 0x40.
- Preload pcF=32'hFFFF_FFFC via redirect -> next pcF=0. Assert rst mid-RUN with flushD=1 -> next cycle all outputs at reset values and state IDLE.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared types and constants for the processor front end.
package processor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register: holds the fetched instruction, its PC and PC+step.
// Priority: flush (bubble) > stall (hold) > load > bubble.
module if_id_register #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_INSTR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             stall_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] instr_i,
    input  logic [WIDTH-1:0] pc_i,
    input  logic [WIDTH-1:0] pc_plus_i,
    output logic [WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_plus_q, pc_plus_d;
    logic             valid_q, valid_d;

    // Next-state selection for the IF/ID contents.
    always_comb begin
        instr_d   = NOP_INSTR;
        pc_d      = '0;
        pc_plus_d = '0;
        valid_d   = 1'b0;
        if (flush_i) begin
            instr_d   = NOP_INSTR;
            pc_d      = '0;
            pc_plus_d = '0;
            valid_d   = 1'b0;
        end else if (stall_i) begin
            instr_d   = instr_q;
            pc_d      = pc_q;
            pc_plus_d = pc_plus_q;
            valid_d   = valid_q;
        end else if (load_i) begin
            instr_d   = instr_i;
            pc_d      = pc_i;
            pc_plus_d = pc_plus_i;
            valid_d   = 1'b1;
        end
    end

    // IF/ID flops with synchronous reset to a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q   <= NOP_INSTR;
            pc_q      <= '0;
            pc_plus_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pc_plus_q <= pc_plus_d;
            valid_q   <= valid_d;
        end
    end

    assign instr_o   = instr_q;
    assign pc_o      = pc_q;
    assign pc_plus_o = pc_plus_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and the IDLE/RUN/HALT fetch FSM and
// feeds the IF/ID register. The instruction word comes back combinationally
// from memory at address pcF in the same cycle.
module fetch_stage
    import processor_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(processor_pkg::RESET_PC),
    parameter logic [WIDTH-1:0] PC_STEP    = WIDTH'(processor_pkg::PC_STEP),
    parameter logic [WIDTH-1:0] NOP_INSTR  = WIDTH'(processor_pkg::NOP_INSTR),
    parameter logic [WIDTH-1:0] HALT_INSTR = WIDTH'(processor_pkg::HALT_INSTR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             switchStart,
    input  logic [WIDTH-1:0] instrF,
    input  logic             stallF,
    input  logic             stallD,
    input  logic             flushD,
    input  logic             pcSrcE,
    input  logic [WIDTH-1:0] pcTargetE,
    output logic [WIDTH-1:0] pcF,
    output logic [WIDTH-1:0] instrD,
    output logic [WIDTH-1:0] pcD,
    output logic [WIDTH-1:0] pcPlus4D,
    output logic             validD,
    output logic             running,
    output logic             halted
);

    fetch_state_t     state_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] target_aligned;
    logic             halt_seen;

    assign pc_plus        = pc_q + PC_STEP;
    assign target_aligned = pcTargetE & ~{{(WIDTH-2){1'b0}}, 2'b11};
    assign halt_seen      = (instrF == HALT_INSTR);

    // PC register and fetch FSM; redirect > stall > halt detect > step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            case (state_q)
                IDLE: begin
                    pc_q <= RESET_PC;
                    if (switchStart) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (pcSrcE) begin
                        pc_q <= target_aligned;
                    end else if (stallF) begin
                        pc_q <= pc_q;
                    end else if (halt_seen) begin
                        state_q <= HALT;
                    end else begin
                        pc_q <= pc_plus;
                    end
                end
                HALT: begin
                    // A taken older branch means the halt was fetched speculatively.
                    if (pcSrcE) begin
                        pc_q    <= target_aligned;
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    pc_q    <= RESET_PC;
                end
            endcase
        end
    end

    assign pcF     = pc_q;
    assign running = (state_q == RUN);
    assign halted  = (state_q == HALT);

    if_id_register #(
        .WIDTH     (WIDTH),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flushD | pcSrcE),
        .stall_i   (stallD),
        .load_i    (state_q == RUN),
        .instr_i   (instrF),
        .pc_i      (pc_q),
        .pc_plus_i (pc_plus),
        .instr_o   (instrD),
        .pc_o      (pcD),
        .pc_plus_o (pcPlus4D),
        .valid_o   (validD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes hand-computed expected
// outputs per cycle, a separate monitor pops and compares after each edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, switchStart, stallF, stallD, flushD, pcSrcE;
    logic [31:0] instrF, pcTargetE;
    logic [31:0] pcF, instrD, pcD, pcPlus4D;
    logic        validD, running, halted;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    bit          stim_done = 1'b0;

    typedef struct {
        logic [31:0] pcF;
        logic [31:0] instrD;
        logic [31:0] pcD;
        logic [31:0] pcP4;
        logic        v;
        logic        r;
        logic        h;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    // Instruction memory model: HALT lives at 0x20, everything else is distinct.
    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0000_0020) return 32'hFFFF_FFFF;
        return a ^ 32'h5A5A_0013;
    endfunction

    assign instrF = imem(pcF);

    fetch_stage #(
        .WIDTH      (32),
        .RESET_PC   (32'h0000_0000),
        .PC_STEP    (32'd4),
        .NOP_INSTR  (32'h0000_0000),
        .HALT_INSTR (32'hFFFF_FFFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .switchStart (switchStart),
        .instrF      (instrF),
        .stallF      (stallF),
        .stallD      (stallD),
        .flushD      (flushD),
        .pcSrcE      (pcSrcE),
        .pcTargetE   (pcTargetE),
        .pcF         (pcF),
        .instrD      (instrD),
        .pcD         (pcD),
        .pcPlus4D    (pcPlus4D),
        .validD      (validD),
        .running     (running),
        .halted      (halted)
    );

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input string nm, input logic r_, input logic sw, input logic sf,
                       input logic sd, input logic fd, input logic src, input logic [31:0] tgt,
                       input logic [31:0] e_pcF, input logic [31:0] e_pcD, input logic e_v,
                       input logic e_r, input logic e_h);
        exp_t e;
        @(negedge clk);
        rst = r_; switchStart = sw; stallF = sf; stallD = sd; flushD = fd;
        pcSrcE = src; pcTargetE = tgt;
        e.pcF    = e_pcF;
        e.v      = e_v;
        e.pcD    = e_v ? e_pcD : 32'h0;
        e.pcP4   = e_v ? e_pcD + 32'd4 : 32'h0;
        e.instrD = e_v ? imem(e_pcD) : 32'h0;
        e.r      = e_r;
        e.h      = e_h;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare the DUT against the oldest expectation after each edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_tests++;
                if (pcF !== e.pcF || instrD !== e.instrD || pcD !== e.pcD ||
                    pcPlus4D !== e.pcP4 || validD !== e.v || running !== e.r ||
                    halted !== e.h) begin
                    n_fail++;
                    $display("FAIL %s: got pcF=%h instrD=%h pcD=%h pcPlus4D=%h validD=%b running=%b halted=%b, want pcF=%h instrD=%h pcD=%h pcPlus4D=%h validD=%b running=%b halted=%b",
                             nm, pcF, instrD, pcD, pcPlus4D, validD, running, halted,
                             e.pcF, e.instrD, e.pcD, e.pcP4, e.v, e.r, e.h);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; switchStart = 1'b0; stallF = 1'b0; stallD = 1'b0;
        flushD = 1'b0; pcSrcE = 1'b0; pcTargetE = 32'h0;

        //  name            rst sw sF sD fD src target          pcF           pcD           v  r  h
        cyc("reset",        1, 0, 0, 0, 0, 0, 32'h0,          32'h0,        32'h0,        0, 0, 0);
        for (int i = 0; i < 5; i++)
            cyc("idle",     0, 0, 0, 0, 0, 0, 32'h0,          32'h0,        32'h0,        0, 0, 0);
        cyc("start",        0, 1, 0, 0, 0, 0, 32'h0,          32'h0,        32'h0,        0, 1, 0);
        cyc("fetch0",       0, 0, 0, 0, 0, 0, 32'h0,          32'h4,        32'h0,        1, 1, 0);
        cyc("fetch4",       0, 0, 0, 0, 0, 0, 32'h0,          32'h8,        32'h4,        1, 1, 0);
        cyc("stall1",       0, 0, 1, 1, 0, 0, 32'h0,          32'h8,        32'h4,        1, 1, 0);
        cyc("stall2",       0, 0, 1, 1, 0, 0, 32'h0,          32'h8,        32'h4,        1, 1, 0);
        cyc("unstall",      0, 0, 0, 0, 0, 0, 32'h0,          32'hC,        32'h8,        1, 1, 0);
        cyc("redir_stallF", 0, 0, 1, 0, 0, 1, 32'h0000_0103,  32'h100,      32'h0,        0, 1, 0);
        cyc("after_redir",  0, 0, 0, 0, 0, 0, 32'h0,          32'h104,      32'h100,      1, 1, 0);
        cyc("redir_18",     0, 0, 0, 0, 0, 1, 32'h18,         32'h18,       32'h0,        0, 1, 0);
        cyc("fetch18",      0, 0, 0, 0, 0, 0, 32'h0,          32'h1C,       32'h18,       1, 1, 0);
        cyc("fetch1c",      0, 0, 0, 0, 0, 0, 32'h0,          32'h20,       32'h1C,       1, 1, 0);
        cyc("halt_detect",  0, 0, 0, 0, 0, 0, 32'h0,          32'h20,       32'h20,       1, 0, 1);
        cyc("halt_sw1",     0, 1, 0, 0, 0, 0, 32'h0,          32'h20,       32'h0,        0, 0, 1);
        cyc("halt_sw0",     0, 0, 0, 0, 0, 0, 32'h0,          32'h20,       32'h0,        0, 0, 1);
        cyc("halt_sw1b",    0, 1, 0, 0, 0, 0, 32'h0,          32'h20,       32'h0,        0, 0, 1);
        cyc("halt_redir",   0, 0, 0, 0, 0, 1, 32'h40,         32'h40,       32'h0,        0, 1, 0);
        cyc("fetch40",      0, 0, 0, 0, 0, 0, 32'h0,          32'h44,       32'h40,       1, 1, 0);
        cyc("fetch44",      0, 0, 0, 0, 0, 0, 32'h0,          32'h48,       32'h44,       1, 1, 0);
        cyc("redir_20",     0, 0, 0, 0, 0, 1, 32'h20,         32'h20,       32'h0,        0, 1, 0);
        cyc("halt_stallF",  0, 0, 1, 0, 0, 0, 32'h0,          32'h20,       32'h20,       1, 1, 0);
        cyc("halt_late",    0, 0, 0, 0, 0, 0, 32'h0,          32'h20,       32'h20,       1, 0, 1);
        cyc("redir_top",    0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF,  32'hFFFF_FFFC, 32'h0,       0, 1, 0);
        cyc("pc_wrap",      0, 0, 0, 0, 0, 0, 32'h0,          32'h0,        32'hFFFF_FFFC, 1, 1, 0);
        cyc("fetch_after",  0, 0, 0, 0, 0, 0, 32'h0,          32'h4,        32'h0,        1, 1, 0);
        cyc("flush_stallD", 0, 0, 0, 1, 1, 0, 32'h0,          32'h8,        32'h0,        0, 1, 0);
        cyc("rst_mid_run",  1, 0, 0, 0, 1, 0, 32'h0,          32'h0,        32'h0,        0, 0, 0);
        cyc("idle_again",   0, 0, 0, 0, 0, 0, 32'h0,          32'h0,        32'h0,        0, 0, 0);
        stim_done = 1'b1;
    end

    // Drain the scoreboard with a bounded wait, then report.
    initial begin
        wait (stim_done);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

endmodule
